conv_encoder_tx: RTL and testbench
==================================

// Module: conv_encoder_tx
// PURPOSE
//  Rate-1/2 convolutional encoder feeding tt_um_viterbi_core's rx_sym stream (upstream stage).
//  Accepts bytes over valid/ready, serializes LSB-first, emits 2-bit symbols over valid/ready.
//  Optional zero-tail flush returns the trellis to state 0 at frame end, matching force_state0.
// PARAMETERS
//  K       3      constraint length; M=K-1 state bits
//  G0_OCT  8'o07  generator 0 (octal); bit i masks reg_val[i]
//  G1_OCT  8'o05  generator 1 (octal)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  in_byte/in_last valid
//  in_ready   out  1  byte accepted when in_valid & in_ready
//  in_byte    in   8  data byte, bit 0 encoded first
//  in_last    in   1  byte ends frame; append M zero tail bits
//  sym_valid  out  1  sym valid
//  sym_ready  in   1  downstream (rx_sym_ready) accepts
//  sym        out  2  {c0,c1}
//  sym_last   out  1  high with final tail symbol of a frame
//  busy       out  1  FSM not IDLE
// BEHAVIOUR
//  - Encoding: reg_val[K-1:0]={enc_state,b}; c0=^(reg_val&G0); c1=^(reg_val&G1);
//    next enc_state={enc_state[M-2:0],b}. Generators truncated to K bits.
//  - FSM IDLE/DATA/TAIL. Reset: IDLE, enc_state=0, bit_cnt=0, tail_cnt=0, sym_idx=0;
//    outputs: in_ready=1, sym_valid=0, sym=0, sym_last=0, busy=0.
//  - IDLE: in_ready=1. On accept: load shift reg, latch in_last, bit_cnt=0 -> DATA.
//    in_ready=0 in DATA/TAIL (no overlap); throughput 8 syms / 9 cycles per byte.
//  - DATA: sym_valid=1; sym computed from registered enc_state and shreg[0].
//    On sym_valid&sym_ready: update enc_state, shift, bit_cnt++. At bit_cnt==7
//    handshake: last latched -> TAIL (tail_cnt=0), else -> IDLE.
//  - TAIL: emit M symbols with b=0; sym_last=1 when tail_cnt==M-1. Final handshake:
//    enc_state is 0 by construction -> IDLE, sym_idx cleared.
//  - Without in_last, enc_state carries across bytes (continuous stream, no flush).
//  - Latency: byte accepted cycle N -> first sym_valid cycle N+1.
//  - Backpressure: while sym_valid & !sym_ready, sym/sym_last/all state held stable.
//    sym_valid never drops without a handshake.
//  - sym_idx: 8-bit count of symbols handshaken since reset/last frame; wraps 255->0.
//  - rst mid-frame: all state to reset values next edge; partial byte/tail discarded.
//  - in_valid in DATA/TAIL ignored (in_ready=0); upstream holds data.
// CONFIGURATION
//  CONV_ENC_ERR_INJECT_EN defined: adds ports err_inj_en(in,1), err_inj_idx(in,8),
//   err_inj_mask(in,2). When err_inj_en and sym_idx==err_inj_idx, sym output is
//   sym^err_inj_mask for that symbol only; enc_state unaffected. Used to exercise
//   decoder error correction.
//  Undefined: ports absent; sym always the clean encoded symbol.
// TESTING
//  1 rst 5 cycles, byte 0x00 no last -> 8 syms 00, sym_last never set, back to IDLE.
//  2 byte 0x01 no last -> syms 11,10,11,00,00,00,00,00; enc_state ends 0.
//  3 byte 0x80 in_last=1 -> 7x 00, then 11, tail 10, 11 with sym_last on 10th sym.
//  4 sym_ready low 5 cycles mid-byte 0x01 -> sym held at current value, no skipped/duplicated syms.
//  5 rst asserted at 4th sym of byte 0xFF -> next cycle sym_valid=0, in_ready=1; byte 0x01 then gives test-2 sequence.
//  6 (CONV_ENC_ERR_INJECT_EN) idx=3, mask=01, byte 0x01 -> 4th sym 01 instead of 00, others as test 2.

Source files
------------

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder: bytes in (LSB first), 2-bit {c0,c1} symbols out, optional zero-tail flush.
// Define CONV_ENC_ERR_INJECT_EN to add err_inj_en/err_inj_idx/err_inj_mask for single-symbol error injection.
module conv_encoder_tx #(
   parameter int         K      = 3,
   parameter logic [7:0] G0_OCT = 8'o07,
   parameter logic [7:0] G1_OCT = 8'o05
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_last,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic [1:0] sym,
   output logic       sym_last,
`ifdef CONV_ENC_ERR_INJECT_EN
   input  logic       err_inj_en,
   input  logic [7:0] err_inj_idx,
   input  logic [1:0] err_inj_mask,
`endif
   output logic       busy
);

   // Handshakes (byte in and symbol out): a transfer happens on a rising edge where
   // valid & ready are both high; valid and its payload hold until then, and ready
   // never depends combinationally on valid.

   localparam int M  = K - 1;
   localparam int TW = (M > 1) ? $clog2(M) : 1;

   localparam logic [K-1:0]  G0        = G0_OCT[K-1:0];
   localparam logic [K-1:0]  G1        = G1_OCT[K-1:0];
   localparam logic [TW-1:0] TAIL_LAST = TW'(M - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_TAIL = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [M-1:0]  enc_state;
   logic [7:0]    shreg;
   logic          last_q;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] tail_cnt;

   logic          cur_bit;
   logic [K-1:0]  reg_val;
   logic [1:0]    clean_sym;
   logic          in_fire;
   logic          sym_fire;

   // Tail symbols encode b=0, which shifts the trellis back to state 0.
   always_comb begin
      cur_bit   = (state == S_DATA) ? shreg[0] : 1'b0;
      reg_val   = {enc_state, cur_bit};
      clean_sym = {^(reg_val & G0), ^(reg_val & G1)};
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      sym_valid = 1'b0;
      sym_last  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_DATA;
         end
         S_DATA: begin
            sym_valid = 1'b1;
            if (sym_ready && (bit_cnt == 3'd7)) state_nxt = last_q ? S_TAIL : S_IDLE;
         end
         S_TAIL: begin
            sym_valid = 1'b1;
            sym_last  = (tail_cnt == TAIL_LAST);
            if (sym_ready && sym_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign in_fire  = in_valid & in_ready;
   assign sym_fire = sym_valid & sym_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         enc_state <= '0;
         shreg     <= '0;
         last_q    <= 1'b0;
         bit_cnt   <= '0;
         tail_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (in_fire) begin
            shreg   <= in_byte;
            last_q  <= in_last;
            bit_cnt <= '0;
         end
         if (sym_fire) begin
            enc_state <= reg_val[M-1:0];
            if (state == S_DATA) begin
               shreg    <= {1'b0, shreg[7:1]};
               bit_cnt  <= bit_cnt + 3'd1;
               tail_cnt <= '0;
            end else begin
               tail_cnt <= tail_cnt + TW'(1);
            end
         end
      end
   end

`ifdef CONV_ENC_ERR_INJECT_EN
   logic [7:0] sym_idx;
   logic [1:0] inj_mask;

   // Symbol index restarts after each flushed frame so injection targets are frame-relative.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym_idx <= '0;
      end else if (sym_fire) begin
         sym_idx <= (state == S_TAIL && sym_last) ? 8'd0 : sym_idx + 8'd1;
      end
   end

   assign inj_mask = (err_inj_en && (sym_idx == err_inj_idx)) ? err_inj_mask : 2'b00;
   assign sym      = sym_valid ? (clean_sym ^ inj_mask) : 2'b00;
`else
   assign sym = sym_valid ? clean_sym : 2'b00;
`endif

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx (K=3, G=7,5): vector table plus backpressure and mid-frame reset sequences.
module tb_conv_encoder_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       in_last;
   logic       sym_valid;
   logic       sym_ready;
   logic [1:0] sym;
   logic       sym_last;
   logic       busy;
`ifdef CONV_ENC_ERR_INJECT_EN
   logic       err_inj_en;
   logic [7:0] err_inj_idx;
   logic [1:0] err_inj_mask;
`endif

   conv_encoder_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .in_last   (in_last),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym       (sym),
      .sym_last  (sym_last),
`ifdef CONV_ENC_ERR_INJECT_EN
      .err_inj_en   (err_inj_en),
      .err_inj_idx  (err_inj_idx),
      .err_inj_mask (err_inj_mask),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // {sym_last, sym} expected for each handshake, in order
   logic [2:0] exp_q[$];

   typedef struct {
      logic [7:0]  b;
      logic        last;
      int          n;
      logic [19:0] s;   // symbol 0 in bits [19:18], symbol 1 in [17:16], ...
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic push_syms(input vec_t v);
      for (int i = 0; i < v.n; i++)
         exp_q.push_back({(v.last && (i == v.n - 1)), v.s[19-2*i -: 2]});
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int cyc = 0;
      in_valid = 1'b1;
      in_byte  = b;
      in_last  = last;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'hA5;
      in_last  = 1'b0;
      check("first_sym_latency", {3'b0, sym_valid}, 4'b0001);
   endtask

   // Collect n symbols; stall sym_ready for stall_len cycles when got == stall_at.
   task automatic collect(input int n, input int stall_at, input int stall_len);
      int got   = 0;
      int cyc   = 0;
      int stall = 0;
      logic [2:0] e;
      while (got < n && cyc < 300) begin
         if (got == stall_at && stall < stall_len) begin
            sym_ready = 1'b0;
            stall++;
            check("hold_stable", {sym_valid, sym_last, sym}, {1'b1, exp_q[0]});
         end else begin
            sym_ready = 1'b1;
            if (sym_valid) begin
               e = exp_q.pop_front();
               check("sym", {1'b0, sym_last, sym}, {1'b0, e});
               got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (got < n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sym_timeout: got %0d symbols expected %0d", got, n);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {1'b0, busy, in_ready, sym_valid}, 4'b0010);
   endtask

   task automatic run_vec(input vec_t v);
      push_syms(v);
      send_byte(v.b, v.last);
      collect(v.n, -1, 0);
      check_idle("back_to_idle");
   endtask

   initial begin
      vec_t v;

      vecs[0] = '{b: 8'h00, last: 1'b0, n: 8,  s: 20'b00_00_00_00_00_00_00_00_00_00};
      vecs[1] = '{b: 8'h01, last: 1'b0, n: 8,  s: 20'b11_10_11_00_00_00_00_00_00_00};
      vecs[2] = '{b: 8'h80, last: 1'b1, n: 10, s: 20'b00_00_00_00_00_00_00_11_10_11};
      vecs[3] = '{b: 8'h03, last: 1'b0, n: 8,  s: 20'b11_01_01_11_00_00_00_00_00_00};
      vecs[4] = '{b: 8'hFF, last: 1'b1, n: 10, s: 20'b11_01_10_10_10_10_10_10_01_11};
      // 0x80 without flush leaves the trellis in state 01; 0x00 then starts 10,11
      vecs[5] = '{b: 8'h80, last: 1'b0, n: 8,  s: 20'b00_00_00_00_00_00_00_11_00_00};
      vecs[6] = '{b: 8'h00, last: 1'b0, n: 8,  s: 20'b10_11_00_00_00_00_00_00_00_00};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      in_last   = 1'b0;
      sym_ready = 1'b0;
`ifdef CONV_ENC_ERR_INJECT_EN
      err_inj_en   = 1'b0;
      err_inj_idx  = 8'd0;
      err_inj_mask = 2'b00;
`endif
      repeat (5) @(negedge clk);
      check("reset_outputs", {in_ready, sym_valid, sym_last, busy}, 4'b1000);
      check("reset_sym", {2'b00, sym}, 4'b0000);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Backpressure: stall 5 cycles while the third symbol of 0x01 is presented
      v = vecs[1];
      push_syms(v);
      send_byte(v.b, v.last);
      collect(v.n, 2, 5);
      check_idle("idle_after_stall");

      // Reset while the 4th symbol of 0xFF is presented; trellis must restart at 0
      sym_ready = 1'b1;
      exp_q.push_back(3'b011);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      send_byte(8'hFF, 1'b0);
      collect(3, -1, 0);
      check("pre_reset_4th_sym", {1'b0, sym_valid, sym}, 4'b0110);
      sym_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", {in_ready, sym_valid, sym_last, busy}, 4'b1000);
      rst = 1'b0;
      run_vec(vecs[1]);

`ifdef CONV_ENC_ERR_INJECT_EN
      rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      err_inj_en   = 1'b1;
      err_inj_idx  = 8'd3;
      err_inj_mask = 2'b01;
      @(negedge clk);
      v = '{b: 8'h01, last: 1'b0, n: 8, s: 20'b11_10_11_01_00_00_00_00_00_00};
      run_vec(v);
      err_inj_en = 1'b0;
`endif

      check("scoreboard_drained", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
